// File: rtl/keypad_pkg.sv
// keypad_pkg: shared sizes, the key-code type and one-hot helpers for the
// 4x4 keypad scanner.
package keypad_pkg;
  localparam int ROWS = 4;
  localparam int COLS = 4;

  typedef logic [3:0] key_code_t;

  // Index of the set bit in a 16-bit one-hot snapshot ({row, col} order).
  function automatic key_code_t onehot_to_code(input logic [15:0] oh);
    key_code_t c;
    c = '0;
    for (int i = 0; i < 16; i++) begin
      if (oh[i]) c = key_code_t'(i);
    end
    return c;
  endfunction

  // True when exactly one key is pressed in the snapshot.
  function automatic logic is_onehot(input logic [15:0] v);
    return (v != '0) && ((v & (v - 16'd1)) == '0);
  endfunction
endpackage

// File: rtl/keypad_sync.sv
// keypad_sync: 2-flop synchronizer for asynchronous inputs, with a
// configurable reset value so idle lines come out of reset inactive.
module keypad_sync #(
  parameter int             W       = 4,
  parameter logic [W-1:0]   RST_VAL = '1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] meta_q, sync_q;

  // Two back-to-back flops; only sync_q is used downstream.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: strobes a 4x4 matrix one row at a time, debounces whole
// 16-bit frame snapshots and emits a one-cycle key event with a 4-bit code.
// Optional auto-repeat is compiled in when KEYPAD_REPEAT_EN is defined.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int CLK_HZ         = 100_000_000,
  parameter int SCAN_HZ        = 1000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_FRAMES  = 250
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ROWS-1:0]   row,
  input  logic [COLS-1:0]   col,
  output key_code_t         key_code,
  output logic              key_valid,
  output logic              key_down
);
  localparam int              DIV    = CLK_HZ / SCAN_HZ;
  localparam int              CW     = $clog2(DIV);
  localparam logic [CW-1:0]   DIV_M1 = CW'(DIV - 1);
  localparam logic [3:0]      DEB_M1 = 4'(DEBOUNCE_SCANS - 1);

  logic [COLS-1:0] col_s;
  logic [CW-1:0]   dwell_q, dwell_d;
  logic [1:0]      row_idx_q, row_idx_d;
  logic [15:0]     snap_q, snap_d, prev_q, prev_d, deb_q, deb_d;
  logic [3:0]      stable_q, stable_d;
  key_code_t       code_q, code_d;
  logic            valid_q, valid_d;
  logic            frame_end, ev_fire, rep_fire;

  keypad_sync #(.W(COLS), .RST_VAL('1)) u_col_sync (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (col),
    .q_o   (col_s)
  );

  // Scan, sample, frame compare, acceptance and press-event detection.
  always_comb begin
    dwell_d   = dwell_q + 1'b1;
    row_idx_d = row_idx_q;
    snap_d    = snap_q;
    prev_d    = prev_q;
    stable_d  = stable_q;
    deb_d     = deb_q;
    code_d    = code_q;
    frame_end = 1'b0;
    ev_fire   = 1'b0;
    if (dwell_q == DIV_M1) begin
      dwell_d   = '0;
      row_idx_d = row_idx_q + 2'd1;
      snap_d[{row_idx_q, 2'b00} +: 4] = ~col_s;
      if (row_idx_q == 2'd3) begin
        // snap_d already holds the row-3 sample taken this cycle
        frame_end = 1'b1;
        prev_d    = snap_d;
        if (snap_d == prev_q) stable_d = (stable_q == 4'd15) ? 4'd15 : stable_q + 4'd1;
        else                  stable_d = '0;
        if (stable_d == DEB_M1) begin
          deb_d = snap_d;
          // only idle -> single key counts as a press
          if (deb_q == '0 && is_onehot(snap_d)) begin
            ev_fire = 1'b1;
            code_d  = onehot_to_code(snap_d);
          end
        end
      end
    end
    valid_d = ev_fire | rep_fire;
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int            RW         = $clog2(2 * REPEAT_FRAMES + 1);
  localparam logic [RW-1:0] REP_LAST   = RW'(2 * REPEAT_FRAMES - 1);
  localparam logic [RW-1:0] REP_RELOAD = RW'(REPEAT_FRAMES);

  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  logic          rep_arm_q, rep_arm_d;

  // Frame counter for auto-repeat: first repeat after 2*REPEAT_FRAMES
  // frames, then every REPEAT_FRAMES, while the pressed key stays alone.
  always_comb begin
    rep_cnt_d = rep_cnt_q;
    rep_arm_d = rep_arm_q;
    rep_fire  = 1'b0;
    if (frame_end) begin
      if (deb_d != deb_q) begin
        rep_cnt_d = '0;
        rep_arm_d = ev_fire;
      end else if (rep_arm_q && deb_q == (16'd1 << code_q)) begin
        if (rep_cnt_q == REP_LAST) begin
          rep_fire  = 1'b1;
          rep_cnt_d = REP_RELOAD;
        end else begin
          rep_cnt_d = rep_cnt_q + 1'b1;
        end
      end
    end
  end

  // Repeat state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rep_cnt_q <= '0;
      rep_arm_q <= 1'b0;
    end else begin
      rep_cnt_q <= rep_cnt_d;
      rep_arm_q <= rep_arm_d;
    end
  end
`else
  logic unused_rep_cfg;
  assign unused_rep_cfg = (REPEAT_FRAMES != 0) & frame_end;
  assign rep_fire       = 1'b0;
`endif

  // Scanner state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      dwell_q   <= '0;
      row_idx_q <= '0;
      snap_q    <= '0;
      prev_q    <= '0;
      deb_q     <= '0;
      stable_q  <= '0;
      code_q    <= '0;
      valid_q   <= 1'b0;
    end else begin
      dwell_q   <= dwell_d;
      row_idx_q <= row_idx_d;
      snap_q    <= snap_d;
      prev_q    <= prev_d;
      deb_q     <= deb_d;
      stable_q  <= stable_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
    end
  end

  assign row       = ~(4'b0001 << row_idx_q);
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_down  = |deb_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed bench for keypad_scanner with DIV=10 (40-cycle
// frames) and DEBOUNCE_SCANS=3. The keypad matrix is modelled from `keys`.
// The auto-repeat scenario is built only when KEYPAD_REPEAT_EN is defined.
module tb_keypad_scanner;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row, col, key_code;
  logic        key_valid, key_down;
  logic [15:0] keys;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int pulse_cnt = 0;
  int last_pulse_cyc = 0;
  logic [3:0] last_code = 4'h0;
  int dbl_cnt = 0;
  logic prev_valid = 1'b0;

  keypad_scanner #(
    .CLK_HZ(1000), .SCAN_HZ(100), .DEBOUNCE_SCANS(3), .REPEAT_FRAMES(5)
  ) dut (
    .clk(clk), .rst(rst), .row(row), .col(col),
    .key_code(key_code), .key_valid(key_valid), .key_down(key_down)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Matrix model: column c is pulled low when its key in the strobed row is closed.
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row[r] && keys[r*4+c]) col[c] = 1'b0;
  end

  // Pulse monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (key_valid === 1'b1) begin
      pulse_cnt      <= pulse_cnt + 1;
      last_pulse_cyc <= cyc;
      last_code      <= key_code;
      if (prev_valid) dbl_cnt <= dbl_cnt + 1;
    end
    prev_valid <= key_valid;
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Leaves the caller in cycle 0 of a frame (row 0 just strobed).
  task automatic sync_frame();
    logic [3:0] prev;
    bit found;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      prev = row;
      @(posedge clk); #1;
      if (prev == 4'b0111 && row == 4'b1110) found = 1'b1;
    end
    if (!found) begin
      n_cmp++; n_bad++;
      $display("FAIL sync_frame: row=%b, required 0111->1110 within 100 cycles", row);
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_row;
    rst = 1'b1; keys = '0;
    step(3);
    n_cmp++; if (row !== 4'b1110) begin n_bad++; $display("FAIL reset_row: got %b want 1110", row); end
    n_cmp++; if (key_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", key_valid); end
    n_cmp++; if (key_down !== 1'b0) begin n_bad++; $display("FAIL reset_down: got %b want 0", key_down); end
    n_cmp++; if (key_code !== 4'h0) begin n_bad++; $display("FAIL reset_code: got %h want 0", key_code); end
    rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      exp_row = ~(4'b0001 << (k / 10));
      n_cmp++;
      if (row !== exp_row) begin n_bad++; $display("FAIL row_walk[%0d]: got %b want %b", k, row, exp_row); end
      step(1);
    end
  endtask

  task automatic test_clean_press();
    int pc0;
    sync_frame();
    pc0 = pulse_cnt;
    keys = 16'h0200;                     // key (2,1)
    step(119);
    n_cmp++; if (key_valid !== 1'b0 || key_down !== 1'b0) begin n_bad++;
      $display("FAIL press_early: valid=%b down=%b want 0 0 at cycle 119", key_valid, key_down); end
    step(1);
    n_cmp++; if (key_valid !== 1'b1) begin n_bad++; $display("FAIL press_valid: got %b want 1 at cycle 120", key_valid); end
    n_cmp++; if (key_code !== 4'h9) begin n_bad++; $display("FAIL press_code: got %h want 9", key_code); end
    n_cmp++; if (key_down !== 1'b1) begin n_bad++; $display("FAIL press_down: got %b want 1", key_down); end
    step(1);
    n_cmp++; if (key_valid !== 1'b0) begin n_bad++; $display("FAIL press_pulse_width: got %b want 0", key_valid); end
    step(60);
    n_cmp++; if (pulse_cnt - pc0 !== 1) begin n_bad++; $display("FAIL press_count: got %0d want 1", pulse_cnt - pc0); end
    sync_frame();
    keys = '0;
    step(119);
    n_cmp++; if (key_down !== 1'b1) begin n_bad++; $display("FAIL release_hold: got %b want 1 at cycle 119", key_down); end
    step(1);
    n_cmp++; if (key_down !== 1'b0) begin n_bad++; $display("FAIL release_down: got %b want 0 at cycle 120", key_down); end
    step(40);
    n_cmp++; if (pulse_cnt - pc0 !== 1) begin n_bad++; $display("FAIL release_event: got %0d pulses want 1", pulse_cnt - pc0); end
  endtask

  task automatic test_bounce();
    int pc0, t0;
    sync_frame();
    pc0 = pulse_cnt; t0 = cyc;
    for (int k = 0; k < 300; k++) begin
      keys = (k >= 100 || ((k / 15) % 2 == 0)) ? 16'h0008 : 16'h0000;  // key (0,3)
      if (k == 200) begin
        n_cmp++; if (pulse_cnt !== pc0) begin n_bad++; $display("FAIL bounce_quiet: got %0d pulses want 0", pulse_cnt - pc0); end
      end
      step(1);
    end
    n_cmp++; if (pulse_cnt - pc0 !== 1) begin n_bad++; $display("FAIL bounce_count: got %0d want 1", pulse_cnt - pc0); end
    n_cmp++; if (last_pulse_cyc - t0 !== 240) begin n_bad++; $display("FAIL bounce_time: got %0d want 240", last_pulse_cyc - t0); end
    n_cmp++; if (last_code !== 4'h3) begin n_bad++; $display("FAIL bounce_code: got %h want 3", last_code); end
    keys = '0;
    step(200);
    n_cmp++; if (key_down !== 1'b0) begin n_bad++; $display("FAIL bounce_release: got %b want 0", key_down); end
  endtask

  task automatic test_multi_key();
    int pc0, t0;
    sync_frame();
    pc0 = pulse_cnt;
    keys = 16'h8010;                     // keys (1,0) and (3,3)
    step(200);
    n_cmp++; if (key_down !== 1'b1) begin n_bad++; $display("FAIL multi_down: got %b want 1", key_down); end
    n_cmp++; if (pulse_cnt !== pc0) begin n_bad++; $display("FAIL multi_event: got %0d pulses want 0", pulse_cnt - pc0); end
    keys = 16'h0010;                     // release (3,3), (1,0) still held
    step(200);
    n_cmp++; if (pulse_cnt !== pc0) begin n_bad++; $display("FAIL multi_partial: got %0d pulses want 0", pulse_cnt - pc0); end
    n_cmp++; if (key_down !== 1'b1) begin n_bad++; $display("FAIL multi_partial_down: got %b want 1", key_down); end
    keys = '0;
    step(200);
    n_cmp++; if (key_down !== 1'b0) begin n_bad++; $display("FAIL multi_released: got %b want 0", key_down); end
    sync_frame();
    t0 = cyc;
    keys = 16'h8000;                     // key (3,3)
    step(160);
    n_cmp++; if (pulse_cnt - pc0 !== 1) begin n_bad++; $display("FAIL single_after_multi: got %0d want 1", pulse_cnt - pc0); end
    n_cmp++; if (last_code !== 4'hF) begin n_bad++; $display("FAIL single_code: got %h want F", last_code); end
    n_cmp++; if (last_pulse_cyc - t0 !== 120) begin n_bad++; $display("FAIL single_time: got %0d want 120", last_pulse_cyc - t0); end
    keys = '0;
    step(200);
  endtask

  task automatic test_reset_mid();
    int pc0;
    sync_frame();
    pc0 = pulse_cnt;
    keys = 16'h0040;                     // key (1,2)
    step(60);
    n_cmp++; if (pulse_cnt !== pc0) begin n_bad++; $display("FAIL midrst_before: got %0d pulses want 0", pulse_cnt - pc0); end
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    n_cmp++; if (key_code !== 4'h0) begin n_bad++; $display("FAIL midrst_code_cleared: got %h want 0", key_code); end
    n_cmp++; if (row !== 4'b1110) begin n_bad++; $display("FAIL midrst_row: got %b want 1110", row); end
    step(119);
    n_cmp++; if (pulse_cnt !== pc0 || key_down !== 1'b0) begin n_bad++;
      $display("FAIL midrst_early: pulses=%0d down=%b want 0 0", pulse_cnt - pc0, key_down); end
    step(1);
    n_cmp++; if (key_valid !== 1'b1) begin n_bad++; $display("FAIL midrst_valid: got %b want 1 at cycle 120", key_valid); end
    n_cmp++; if (key_code !== 4'h6) begin n_bad++; $display("FAIL midrst_code: got %h want 6", key_code); end
    keys = '0;
    step(200);
    n_cmp++; if (pulse_cnt - pc0 !== 1) begin n_bad++; $display("FAIL midrst_count: got %0d want 1", pulse_cnt - pc0); end
  endtask

`ifdef KEYPAD_REPEAT_EN
  task automatic test_repeat();
    int pc0;
    logic exp_v;
    sync_frame();
    pc0 = pulse_cnt;
    keys = 16'h0001;                     // key (0,0)
    // event at 120; repeats 10, 15 and 20 frames (400/600/800 cycles) later
    for (int k = 1; k <= 930; k++) begin
      step(1);
      exp_v = (k == 120 || k == 520 || k == 720 || k == 920);
      n_cmp++;
      if (key_valid !== exp_v) begin n_bad++; $display("FAIL repeat_cycle[%0d]: got %b want %b", k, key_valid, exp_v); end
    end
    n_cmp++; if (last_code !== 4'h0) begin n_bad++; $display("FAIL repeat_code: got %h want 0", last_code); end
    keys = '0;
    step(300);
    n_cmp++; if (pulse_cnt - pc0 !== 4) begin n_bad++; $display("FAIL repeat_stop: got %0d pulses want 4", pulse_cnt - pc0); end
  endtask
`endif

  task automatic test_pulse_shape();
    n_cmp++; if (dbl_cnt !== 0) begin n_bad++; $display("FAIL valid_back_to_back: got %0d want 0", dbl_cnt); end
  endtask

  initial begin
    rst = 1'b1; keys = '0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_multi_key();
    test_reset_mid();
`ifdef KEYPAD_REPEAT_EN
    test_repeat();
`endif
    test_pulse_shape();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required bench completion");
    $fatal(1);
  end
endmodule
